desplazador_secuencial: RTL and testbench

- Parametrised sequential shift unit; successor to the fixed 4-bit combinational left shifter.
- Shifts a WIDTH-bit operand by B positions, one bit per clock.
- Selectable mode: logical left, logical right, arithmetic right, and optional rotate left.
- Uses a start/busy/done handshake and sits as a multi-cycle functional unit beside the lab ALU blocks.

---
 rtl/desplazador_secuencial.sv | 137 +++++++++++++
 tb/tb_desplazador_secuencial.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/desplazador_secuencial.sv
// desplazador_secuencial: multi-cycle shift unit, one bit position per clock.
// Modes: 00 LSL, 01 LSR, 10 ASR, 11 ROL when DESPLAZADOR_ROT_EN is defined
// (otherwise mode 11 is handled as LSL, including overflow tracking).
// Handshake: start is taken only in IDLE; done pulses for one cycle when the
// result register E and the ovf flag have just been updated.
module desplazador_secuencial #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   B,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] E,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] wreg_q, wreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] shifted;
    logic             lsl_out;

    // One-position shift of the working register for the latched mode.
    // lsl_out is the bit leaving the MSB on a left logical shift, used for ovf.
    always_comb begin
        shifted = {wreg_q[WIDTH-2:0], 1'b0};
        lsl_out = wreg_q[WIDTH-1];
        case (mode_q)
            2'b01: begin
                shifted = {1'b0, wreg_q[WIDTH-1:1]};
                lsl_out = 1'b0;
            end
            2'b10: begin
                shifted = {wreg_q[WIDTH-1], wreg_q[WIDTH-1:1]};
                lsl_out = 1'b0;
            end
`ifdef DESPLAZADOR_ROT_EN
            2'b11: begin
                shifted = {wreg_q[WIDTH-2:0], wreg_q[WIDTH-1]};
                lsl_out = 1'b0;
            end
`endif
            default: begin
                shifted = {wreg_q[WIDTH-2:0], 1'b0};
                lsl_out = wreg_q[WIDTH-1];
            end
        endcase
    end

    // Next-state and datapath updates; everything holds unless the state acts.
    always_comb begin
        state_d   = state_q;
        wreg_d    = wreg_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        ovf_acc_d = ovf_acc_q;
        e_d       = e_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wreg_d    = A;
                    cnt_d     = B;
                    mode_d    = mode;
                    ovf_acc_d = 1'b0;
                    if (B == '0) begin
                        // Zero shift: result is the operand itself.
                        e_d     = A;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                wreg_d    = shifted;
                cnt_d     = cnt_q - SHW'(1);
                ovf_acc_d = ovf_acc_q | lsl_out;
                if (cnt_q == SHW'(1)) begin
                    e_d     = shifted;
                    ovf_d   = ovf_acc_q | lsl_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wreg_q    <= '0;
            cnt_q     <= '0;
            mode_q    <= 2'b00;
            ovf_acc_q <= 1'b0;
            e_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wreg_q    <= wreg_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            ovf_acc_q <= ovf_acc_d;
            e_q       <= e_d;
            ovf_q     <= ovf_d;
        end
    end

    assign E    = e_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_desplazador_secuencial.sv
// Bench for desplazador_secuencial: directed vector table on an 8-bit
// instance, hand-written multi-cycle sequences (reset, start-while-busy,
// mid-operation reset, result hold) and an exhaustive sweep of a 4-bit
// instance. Rotate expectations follow DESPLAZADOR_ROT_EN.
module tb_desplazador_secuencial;

    logic clk = 1'b0;
    logic rst_n;

    logic [7:0] a8;
    logic [2:0] b8;
    logic [1:0] mode8;
    logic       start8;
    logic [7:0] e8;
    logic       busy8, done8, ovf8;

    logic [3:0] a4;
    logic [1:0] b4;
    logic [1:0] mode4;
    logic       start4;
    logic [3:0] e4;
    logic       busy4, done4, ovf4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    desplazador_secuencial #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .mode(mode8), .E(e8), .busy(busy8), .done(done8), .ovf(ovf8)
    );

    desplazador_secuencial #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .mode(mode4), .E(e4), .busy(busy4), .done(done4), .ovf(ovf4)
    );

    typedef struct {
        logic [7:0] a;
        logic [2:0] b;
        logic [1:0] m;
        logic [7:0] exp_e;
        logic       exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one request on the 8-bit unit, scramble the inputs after capture,
    // and count rising edges (start edge included) until done is seen.
    task automatic op8(input logic [7:0] a, input logic [2:0] b, input logic [1:0] m,
                       output int edges, output bit seen);
        @(negedge clk);
        a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        start8 = 1'b0; a8 = ~a; b8 = b + 3'd1; mode8 = m + 2'd1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [1:0] b, input logic [1:0] m,
                       output int edges, output bit seen);
        @(negedge clk);
        a4 = a; b4 = b; mode4 = m; start4 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        start4 = 1'b0; a4 = ~a;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done4) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    initial begin
        vec_t vecs[9];
        int   edges;
        bit   seen;
        bit   extra_done;
        bit   busy_seen;
        logic [7:0] hold_e;

        vecs[0] = '{8'h0F, 3'd3, 2'b00, 8'h78, 1'b0};
        vecs[1] = '{8'hF0, 3'd2, 2'b00, 8'hC0, 1'b1};
        vecs[2] = '{8'h90, 3'd3, 2'b10, 8'hF2, 1'b0};
        vecs[3] = '{8'h90, 3'd3, 2'b01, 8'h12, 1'b0};
        vecs[4] = '{8'hA5, 3'd0, 2'b00, 8'hA5, 1'b0};
        vecs[5] = '{8'h01, 3'd7, 2'b00, 8'h80, 1'b0};
        vecs[6] = '{8'h80, 3'd1, 2'b01, 8'h40, 1'b0};
        vecs[7] = '{8'h40, 3'd2, 2'b00, 8'h00, 1'b1};
`ifdef DESPLAZADOR_ROT_EN
        vecs[8] = '{8'h81, 3'd1, 2'b11, 8'h03, 1'b0};
`else
        vecs[8] = '{8'h81, 3'd1, 2'b11, 8'h02, 1'b1};
`endif

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; mode8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0; mode4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_E", e8, 8'h00);
        check("reset_busy", busy8, 1'b0);
        check("reset_done", done8, 1'b0);
        check("reset_ovf", ovf8, 1'b0);
        $display("reset: E=%0h busy=%0b done=%0b ovf=%0b", e8, busy8, done8, ovf8);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].m, edges, seen);
            check($sformatf("vec%0d_done_seen", i), seen, 1'b1);
            check($sformatf("vec%0d_latency", i), edges, vecs[i].b + 1);
            check($sformatf("vec%0d_E", i), e8, vecs[i].exp_e);
            check($sformatf("vec%0d_ovf", i), ovf8, vecs[i].exp_ovf);
            check($sformatf("vec%0d_busy", i), busy8, 1'b1);
            @(negedge clk);
            check($sformatf("vec%0d_idle_done", i), done8, 1'b0);
            check($sformatf("vec%0d_idle_busy", i), busy8, 1'b0);
            $display("vec%0d: A=%0h B=%0d mode=%0d -> E=%0h ovf=%0b edges=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].m, e8, ovf8, edges);
        end

        // Result hold: idle cycles with moving inputs leave E/ovf untouched.
        hold_e = e8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a8 = 8'(i * 37); b8 = 3'(i); mode8 = 2'(i);
        end
        check("hold_E", e8, vecs[8].exp_e);
        check("hold_ovf", ovf8, vecs[8].exp_ovf);
        $display("hold: E=%0h (was %0h)", e8, hold_e);

        // start held high while busy: second request must be ignored.
        @(negedge clk);
        a8 = 8'h0F; b8 = 3'd3; mode8 = 2'b00; start8 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        a8 = 8'hFF; b8 = 3'd1; mode8 = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) start8 = 1'b0;
            if (done8) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
        end
        start8 = 1'b0;
        check("busy_start_seen", seen, 1'b1);
        check("busy_start_latency", edges, 4);
        check("busy_start_E", e8, 8'h78);
        check("busy_start_ovf", ovf8, 1'b0);
        extra_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done8) extra_done = 1'b1;
        end
        check("busy_start_no_extra_done", extra_done, 1'b0);
        check("busy_start_E_kept", e8, 8'h78);
        $display("start-while-busy: E=%0h edges=%0d", e8, edges);

        // Asynchronous reset pulse in the middle of a long shift.
        @(negedge clk);
        a8 = 8'hFF; b8 = 3'd7; mode8 = 2'b00; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset_busy_before", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_E", e8, 8'h00);
        check("midreset_busy", busy8, 1'b0);
        check("midreset_done", done8, 1'b0);
        check("midreset_ovf", ovf8, 1'b0);
        rst_n = 1'b1;
        extra_done = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) extra_done = 1'b1;
            if (busy8) busy_seen = 1'b1;
        end
        check("midreset_no_done", extra_done, 1'b0);
        check("midreset_stays_idle", busy_seen, 1'b0);
        $display("mid-shift reset: E=%0h busy=%0b", e8, busy8);

        // Exhaustive 4-bit sweep of LSL, LSR and ASR.
        for (int m = 0; m < 3; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 4; b++) begin
                    logic [3:0] av;
                    logic [7:0] wide;
                    logic [3:0] exp_e;
                    logic       exp_ovf;
                    int         err0;
                    av = 4'(a);
                    err0 = errors;
                    wide = {4'b0000, av} << b;
                    if (m == 0) begin
                        exp_e = wide[3:0];
                        exp_ovf = |wide[7:4];
                    end else if (m == 1) begin
                        exp_e = av >> b;
                        exp_ovf = 1'b0;
                    end else begin
                        exp_e = $signed(av) >>> b;
                        exp_ovf = 1'b0;
                    end
                    op4(av, 2'(b), 2'(m), edges, seen);
                    check("ex_done_seen", seen, 1'b1);
                    check("ex_latency", edges, b + 1);
                    check($sformatf("ex_E m%0d a%0h b%0d", m, a, b), e4, exp_e);
                    check($sformatf("ex_ovf m%0d a%0h b%0d", m, a, b), ovf4, exp_ovf);
                    @(negedge clk);
                    check("ex_busy_after", busy4, 1'b0);
                    $display("ex: mode=%0d A=%0h B=%0d -> E=%0h ovf=%0b", m, a, b, e4, ovf4);
                    if (errors != err0)
                        $fatal(1, "exhaustive sweep stopped at mode=%0d A=%0h B=%0d", m, a, b);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
